// File: rtl/notgate_check_seq.sv
// Sweeps every stimulus value across N_IMPL inverter implementations
// and accumulates per-implementation mismatch results.
module notgate_check_seq #(
    parameter int WIDTH  = 1,
    parameter int N_IMPL = 3,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [WIDTH-1:0]        stim_a,
    input  logic [N_IMPL*WIDTH-1:0] resp_b,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IMPL-1:0]       fail_mask,
    output logic [ERR_W-1:0]        err_count,
    output logic [WIDTH-1:0]        first_fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = $clog2(N_IMPL + 1);
    localparam int SW = ERR_W + PW;
    localparam logic [SW-1:0] SAT = SW'({ERR_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]     settle_cnt;
    logic              ff_seen;
    logic [N_IMPL-1:0] mism;
    logic [SW-1:0]     err_sum;
    logic [ERR_W-1:0]  err_nxt;
    logic              last_vec;

    assign last_vec = &stim_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = S_WAIT;
            S_WAIT:   if (settle_cnt == '0) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = last_vec ? S_FINISH : S_DRIVE;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_DRIVE) ||
               (state == S_WAIT)  ||
               (state == S_CHECK);
        done = (state == S_FINISH);
    end

    // Case-inequality so an undriven or X response counts as a mismatch
    always_comb begin
        mism = '0;
        for (int i = 0; i < N_IMPL; i++) begin
            mism[i] = (resp_b[i*WIDTH +: WIDTH] !== ~stim_a);
        end
    end

    always_comb begin
        err_sum = SW'(err_count);
        for (int i = 0; i < N_IMPL; i++) begin
            err_sum = err_sum + SW'(mism[i]);
        end
        if (err_sum > SAT) begin
            err_nxt = '1;
        end else begin
            err_nxt = err_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stim_a         <= '0;
            pass           <= 1'b0;
            fail_mask      <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            settle_cnt     <= '0;
            ff_seen        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        stim_a         <= '0;
                        pass           <= 1'b0;
                        fail_mask      <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        ff_seen        <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= CW'(SETTLE - 1);
                end
                S_WAIT: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    fail_mask <= fail_mask | mism;
                    err_count <= err_nxt;
                    if ((|mism) && !ff_seen) begin
                        first_fail_vec <= stim_a;
                        ff_seen        <= 1'b1;
                    end
                    // pass must already be valid while done is high
                    if (last_vec) begin
                        pass <= ((fail_mask | mism) == '0);
                    end else begin
                        stim_a <= stim_a + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_notgate_check_seq.sv
// Bench for notgate_check_seq: two configurations, a sweep-level
// reference model, a per-cycle compare process and literal checks.
module tb_notgate_check_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v;
    logic [1:0] start_v;
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [1:0] pass_w;

    logic [0:0] stim_a;
    logic [2:0] resp_a;
    logic [2:0] mask_a;
    logic [7:0] err_a;
    logic [0:0] ffv_a;

    logic [1:0] stim_b;
    logic [5:0] resp_b;
    logic [2:0] mask_b;
    logic [1:0] err_b;
    logic [1:0] ffv_b;

    notgate_check_seq #(
        .WIDTH(1), .N_IMPL(3), .SETTLE(2), .ERR_W(8)
    ) u_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
        .stim_a(stim_a), .resp_b(resp_a),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_mask(mask_a), .err_count(err_a),
        .first_fail_vec(ffv_a)
    );

    notgate_check_seq #(
        .WIDTH(2), .N_IMPL(3), .SETTLE(1), .ERR_W(2)
    ) u_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
        .stim_a(stim_b), .resp_b(resp_b),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_mask(mask_b), .err_count(err_b),
        .first_fail_vec(ffv_b)
    );

    // implementation behaviour: 0 inverter, 1 buffer, 2 stuck-at-0
    int mode [2][3];

    function automatic int impl_out(int md, int a, int w);
        int m;
        m = (1 << w) - 1;
        case (md)
            0:       return ~a & m;
            1:       return a & m;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        int t;
        t = 0;
        resp_a = '0;
        resp_b = '0;
        for (int i = 0; i < 3; i++) begin
            t = impl_out(mode[0][i], int'(stim_a), 1);
            resp_a[i] = t[0];
            t = impl_out(mode[1][i], int'(stim_b), 2);
            resp_b[i*2 +: 2] = t[1:0];
        end
    end

    function automatic int wid(int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int settle(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int emax(int d);
        return (d == 0) ? 255 : 3;
    endfunction

    function automatic int lat(int d);
        return (1 << wid(d)) * (settle(d) + 2) + 1;
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, int d, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d",
                     nm, d, act, exp);
        end
    endtask

    // sweep outcome computed directly from the implementation modes
    task automatic calc(input int d, output int p, output int mk,
                        output int er, output int fv);
        int tot;
        int found;
        int m;
        tot = 0;
        found = 0;
        mk = 0;
        fv = 0;
        m = (1 << wid(d)) - 1;
        for (int v = 0; v <= m; v++) begin
            for (int i = 0; i < 3; i++) begin
                if (impl_out(mode[d][i], v, wid(d)) != (~v & m)) begin
                    tot++;
                    mk = mk | (1 << i);
                    if (found == 0) begin
                        fv = v;
                        found = 1;
                    end
                end
            end
        end
        er = (tot > emax(d)) ? emax(d) : tot;
        p = (mk == 0) ? 1 : 0;
    endtask

    // model: mk = cycles since accepted start (0 = idle)
    int mk_k [2];
    int m_stim [2];
    int m_pass [2];
    int m_mask [2];
    int m_err [2];
    int m_ffv [2];
    int f_pass [2];
    int f_mask [2];
    int f_err [2];
    int f_ffv [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_v[d]) begin
                mk_k[d] = 0;
                m_stim[d] = 0;
                m_pass[d] = 0;
                m_mask[d] = 0;
                m_err[d] = 0;
                m_ffv[d] = 0;
            end else if (mk_k[d] == 0) begin
                if (start_v[d]) begin
                    mk_k[d] = 1;
                    m_stim[d] = 0;
                    m_pass[d] = 0;
                    m_mask[d] = 0;
                    m_err[d] = 0;
                    m_ffv[d] = 0;
                    calc(d, f_pass[d], f_mask[d], f_err[d], f_ffv[d]);
                end
            end else begin
                mk_k[d]++;
                if (mk_k[d] > lat(d)) begin
                    mk_k[d] = 0;
                end else if (mk_k[d] == lat(d)) begin
                    m_stim[d] = (1 << wid(d)) - 1;
                    m_pass[d] = f_pass[d];
                    m_mask[d] = f_mask[d];
                    m_err[d] = f_err[d];
                    m_ffv[d] = f_ffv[d];
                end else begin
                    m_stim[d] = (mk_k[d] - 1) / (settle(d) + 2);
                end
            end
        end
    end

    function automatic int a_stim(int d);
        return d ? int'(stim_b) : int'(stim_a);
    endfunction
    function automatic int a_mask(int d);
        return d ? int'(mask_b) : int'(mask_a);
    endfunction
    function automatic int a_err(int d);
        return d ? int'(err_b) : int'(err_a);
    endfunction
    function automatic int a_ffv(int d);
        return d ? int'(ffv_b) : int'(ffv_a);
    endfunction

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, int'(busy_w[d]),
                    (mk_k[d] >= 1 && mk_k[d] < lat(d)) ? 1 : 0);
                chk("done", d, int'(done_w[d]),
                    (mk_k[d] == lat(d)) ? 1 : 0);
                chk("stim", d, a_stim(d), m_stim[d]);
                if (mk_k[d] == 0 || mk_k[d] == lat(d)) begin
                    chk("pass", d, int'(pass_w[d]), m_pass[d]);
                    chk("mask", d, a_mask(d), m_mask[d]);
                    chk("err", d, a_err(d), m_err[d]);
                    chk("ffv", d, a_ffv(d), m_ffv[d]);
                end
            end
        end
    end

    task automatic run(input int d, output int l);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        l = 1;
        while (!done_w[d] && l < 200) begin
            @(negedge clk);
            l++;
        end
        if (!done_w[d]) begin
            chk("timeout", d, l, lat(d));
        end
    endtask

    initial begin
        int l;
        int dn;
        int at;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) mode[d][i] = 0;
        end
        rst_v = 2'b11;
        start_v = 2'b00;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst_v = 2'b00;
        chk("rst_err", 0, int'(err_a), 0);
        chk("rst_busy", 0, int'(busy_w[0]), 0);

        // clean sweep, width 1
        run(0, l);
        chk("t1_lat", 0, l, 9);
        chk("t1_pass", 0, int'(pass_w[0]), 1);
        chk("t1_mask", 0, int'(mask_a), 0);
        chk("t1_stim", 0, int'(stim_a), 1);
        @(negedge clk);

        // implementation 1 behaves as a buffer
        mode[0][1] = 1;
        run(0, l);
        chk("t2_mask", 0, int'(mask_a), 3'b010);
        chk("t2_err", 0, int'(err_a), 2);
        chk("t2_ffv", 0, int'(ffv_a), 0);
        chk("t2_pass", 0, int'(pass_w[0]), 0);
        repeat (3) @(negedge clk);
        mode[0][1] = 0;

        // width 2, implementation 2 stuck at 0
        mode[1][2] = 2;
        run(1, l);
        chk("t3_lat", 1, l, 13);
        chk("t3_err", 1, int'(err_b), 3);
        chk("t3_mask", 1, int'(mask_b), 3'b100);
        chk("t3_ffv", 1, int'(ffv_b), 0);
        @(negedge clk);

        // every implementation wrong on every vector
        for (int i = 0; i < 3; i++) mode[1][i] = 1;
        run(1, l);
        chk("t6_err", 1, int'(err_b), 3);
        chk("t6_mask", 1, int'(mask_b), 3'b111);
        chk("t6_pass", 1, int'(pass_w[1]), 0);
        @(negedge clk);

        // reset during WAIT of vector 1, start in the same cycle
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_pre_stim", 0, int'(stim_a), 1);
        rst_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        start_v[0] = 1'b0;
        chk("t4_busy", 0, int'(busy_w[0]), 0);
        chk("t4_stim", 0, int'(stim_a), 0);
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_w[0]) dn++;
        end
        chk("t4_nodone", 0, dn, 0);
        run(0, l);
        chk("t4_lat", 0, l, 9);
        chk("t4_pass", 0, int'(pass_w[0]), 1);
        @(negedge clk);

        // start held high throughout the sweep, incl. FINISH
        start_v[0] = 1'b1;
        dn = 0;
        at = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (done_w[0]) begin
                dn++;
                at = c;
            end
        end
        start_v[0] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_w[0]) dn++;
        end
        chk("t5_ndone", 0, dn, 1);
        chk("t5_at", 0, at, 9);
        chk("t5_idle", 0, int'(busy_w[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/notgate_check_seq.md
Name: notgate_check_seq

Overview:
Self-checking stimulus sequencer for the inverter implementations (dataflow, behavioural, structural).
- Drives one shared stimulus bus to all N_IMPL inverter instances and waits a programmable settle time.
- Samples every implementation's output, compares each against the bitwise inverse of the stimulus, and accumulates per-implementation pass/fail status.
- Sits alongside the inverter instances in the gate-equivalence harness and replaces hand-written delay/monitor sequences.

Parameters:
WIDTH, 1, stimulus/response width per implementation (bits)
N_IMPL, 3, number of inverter implementations under comparison
SETTLE, 2, cycles between stimulus update and response sample (minimum 1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a sweep when idle
stim_a  output  WIDTH  stimulus driven to every implementation's input
resp_b  input  N_IMPL*WIDTH  concatenated outputs; slice i = bits [i*WIDTH +: WIDTH]
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse at sweep completion
pass  output  1  high when the last sweep had zero mismatches; valid while done is high and afterwards
fail_mask  output  N_IMPL  bit i sticky-set if implementation i ever mismatched in the current sweep
err_count  output  ERR_W  total mismatching (vector, implementation) pairs; saturates at all-ones
first_fail_vec  output  WIDTH  stimulus value of the first mismatch in the sweep; 0 if none

Behaviour:
- Reset, synchronous, rst high at a rising edge: state=IDLE; stim_a=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, first_fail_vec=0; settle counter and internal first-fail flag cleared.
- rst has priority over all other inputs. Reset mid-sweep aborts immediately; no done pulse is produced.
- States: IDLE, DRIVE, WAIT, CHECK, FINISH.
- IDLE:
  - start=1 -> DRIVE next cycle.
  - On acceptance, clear fail_mask, err_count, first_fail_vec, pass and the first-fail flag; set stim_a=0 and busy=1.
  - start=0 -> remain in IDLE; all outputs hold.
- DRIVE: stim_a holds the current vector; load settle counter with SETTLE-1; -> WAIT.
- WAIT: decrement the settle counter each cycle; -> CHECK when it reaches 0. With SETTLE=1, WAIT lasts exactly one cycle.
- CHECK: for each i, mismatch_i = (resp_b slice i != ~stim_a).
  - fail_mask |= mismatch vector.
  - err_count += popcount(mismatch), saturating at 2^ERR_W-1.
  - If any mismatch_i is set and the first-fail flag is clear: first_fail_vec = stim_a, set the flag.
  - If stim_a == all-ones: -> FINISH. Otherwise stim_a increments by 1 -> DRIVE.
- FINISH: done=1 for exactly one cycle; pass = (fail_mask==0 including this cycle's update); busy=0; -> IDLE. stim_a holds the last vector.
- Timing per vector: SETTLE+2 cycles (DRIVE 1 + WAIT SETTLE + CHECK 1).
- Sweep length: 2^WIDTH vectors; total latency from start edge to done = 2^WIDTH*(SETTLE+2)+1 cycles.
- Ignored start: start while busy is ignored, as is start in the same cycle as rst. start during the FINISH cycle is ignored; a new start is accepted in IDLE from the next cycle.
- Wrap-around: stim_a never wraps; the all-ones vector is the terminal condition.
- Results (pass, fail_mask, err_count, first_fail_vec) hold after done until the next accepted start or reset.
- resp_b is sampled only in CHECK; X/Z on resp_b counts as a mismatch (compare with !==-equivalent semantics in simulation; synthesised logic uses plain !=).

Test Plan:
1. WIDTH=1, SETTLE=2, all three implementations correct; pulse start -> stim_a goes 0 then 1; done after 9 cycles; pass=1, fail_mask=000, err_count=0, first_fail_vec=0.
2. Implementation 1 output forced to stim_a (buffer instead of inverter) -> fail_mask=010, err_count=2, first_fail_vec=0, pass=0.
3. WIDTH=2, implementation 2 stuck-at-0 -> mismatches at stim_a=0,1,2 only (expected ~a nonzero); err_count=3, fail_mask=100, first_fail_vec=0.
4. rst asserted during WAIT of vector 1 -> next cycle all outputs at reset values; no done pulse; a subsequent start runs a full clean sweep.
5. start pulsed repeatedly while busy -> single sweep, exactly one done pulse at the nominal latency.
6. ERR_W=2, WIDTH=2, all three implementations faulty on every vector -> err_count saturates at 3; fail_mask=111; pass=0.
